smc_axis_scheduler: RTL and testbench

SMC_AXIS_SCHEDULER -- requirements
Module: smc_axis_scheduler

---
 rtl/smc_axis_scheduler.sv | 263 ++++++++++++++++++++++++++
 tb/tb_smc_axis_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smc_axis_scheduler.sv
// smc_axis_scheduler
// Time-multiplexes one combinational sliding-mode-control core across
// N_AXIS axes. Once per control period (TICK_DIV clocks) it requests a
// sensor sample set and snapshots every axis. It then walks the axes one at
// a time: it presents the operands to the core, waits SETTLE cycles for the
// core to settle, and captures the saturated result.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   en                  scheduler enable; dropping it abandons a running frame
//   clr_err             clears the sticky error flags (a same-cycle set wins)
//   sample_req/ack      handshake with the sensor block
//   theta_*_i           per-axis signed 32-bit sensor values, axis k at [32k+31:32k]
//   core_*              operands to / result from the shared SMC core
//   u_axis              per-axis saturated control output, axis k at [16k+15:16k]
//   u_valid             one-cycle pulse when a full frame has been captured
//   busy                FSM is outside IDLE
//   overrun_err         a tick arrived while a frame was still running
//   timeout_err         the sensor block did not ack within ACK_TO cycles
//
// SETTLE must be at least 1 and TICK_DIV at least 2.

module smc_axis_scheduler #(
    parameter int                 N_AXIS   = 4,
    parameter int                 TICK_DIV = 5000,
    parameter int                 SETTLE   = 2,
    parameter int                 ACK_TO   = 64,
    parameter logic signed [15:0] U_LIM    = 16'sd2047
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr_err,
    output logic                   sample_req,
    input  logic                   sample_ack,
    input  logic [32*N_AXIS-1:0]   theta_dot_i,
    input  logic [32*N_AXIS-1:0]   theta_e_i,
    input  logic [32*N_AXIS-1:0]   theta_dote_i,
    output logic [31:0]            core_u_t,
    output logic [31:0]            core_theta_dot,
    output logic [31:0]            core_theta_e,
    output logic [31:0]            core_theta_dote,
    input  logic [15:0]            core_u,
    output logic [16*N_AXIS-1:0]   u_axis,
    output logic                   u_valid,
    output logic                   busy,
    output logic                   overrun_err,
    output logic                   timeout_err
);

    localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WCW = $clog2(((ACK_TO > SETTLE) ? ACK_TO : SETTLE) + 1);
    localparam int IW  = (N_AXIS > 1) ? $clog2(N_AXIS) : 1;

    localparam logic [TCW-1:0] TICK_LAST   = TCW'(TICK_DIV - 1);
    localparam logic [WCW-1:0] ACK_LAST    = WCW'(ACK_TO - 1);
    localparam logic [WCW-1:0] SETTLE_LAST = WCW'(SETTLE - 1);
    localparam logic [IW-1:0]  IDX_LAST    = IW'(N_AXIS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [TCW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [WCW-1:0]         wait_cnt_q, wait_cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   sample_req_q, sample_req_d;
    logic                   overrun_q, overrun_d;
    logic                   timeout_q, timeout_d;
    logic [32*N_AXIS-1:0]   snap_dot_q, snap_dot_d;
    logic [32*N_AXIS-1:0]   snap_e_q, snap_e_d;
    logic [32*N_AXIS-1:0]   snap_dote_q, snap_dote_d;
    logic [32*N_AXIS-1:0]   fb_q, fb_d;
    logic [16*N_AXIS-1:0]   u_axis_q, u_axis_d;
    logic [31:0]            op_u_t_q, op_u_t_d;
    logic [31:0]            op_dot_q, op_dot_d;
    logic [31:0]            op_e_q, op_e_d;
    logic [31:0]            op_dote_q, op_dote_d;

    logic                   tick;
    logic                   timeout_set;
    logic signed [15:0]     core_u_s;
    logic signed [15:0]     u_clamped;

    // Control-period counter; it is held at zero while disabled so that
    // re-enabling always yields a full period before the next request.
    always_comb begin
        tick       = en && (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick_cnt_q;
        if (!en || tick) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end
    end

    // Symmetric signed saturation of the core result. The most negative
    // code (-32768) lands on -U_LIM, not on its own magnitude.
    always_comb begin
        core_u_s = $signed(core_u);
        if (core_u_s > U_LIM) begin
            u_clamped = U_LIM;
        end else if (core_u_s < -U_LIM) begin
            u_clamped = -U_LIM;
        end else begin
            u_clamped = core_u_s;
        end
    end

    // Frame sequencer. Dropping en abandons the frame from any busy state
    // and keeps whatever axes were already captured. wait_cnt_q is shared
    // between the ack timeout in REQ and the settle delay in WAIT.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        idx_d        = idx_q;
        sample_req_d = sample_req_q;
        snap_dot_d   = snap_dot_q;
        snap_e_d     = snap_e_q;
        snap_dote_d  = snap_dote_q;
        fb_d         = fb_q;
        u_axis_d     = u_axis_q;
        op_u_t_d     = op_u_t_q;
        op_dot_d     = op_dot_q;
        op_e_d       = op_e_q;
        op_dote_d    = op_dote_q;
        timeout_set  = 1'b0;

        if ((state_q != S_IDLE) && !en) begin
            state_d      = S_IDLE;
            sample_req_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        state_d      = S_REQ;
                        sample_req_d = 1'b1;
                        wait_cnt_d   = '0;
                    end
                end
                S_REQ: begin
                    if (sample_ack) begin
                        snap_dot_d   = theta_dot_i;
                        snap_e_d     = theta_e_i;
                        snap_dote_d  = theta_dote_i;
                        idx_d        = '0;
                        sample_req_d = 1'b0;
                        state_d      = S_LOAD;
                    end else if (wait_cnt_q == ACK_LAST) begin
                        timeout_set  = 1'b1;
                        sample_req_d = 1'b0;
                        state_d      = S_IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                S_LOAD: begin
                    op_u_t_d   = fb_q[32*idx_q +: 32];
                    op_dot_d   = snap_dot_q[32*idx_q +: 32];
                    op_e_d     = snap_e_q[32*idx_q +: 32];
                    op_dote_d  = snap_dote_q[32*idx_q +: 32];
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt_q == SETTLE_LAST) begin
                        state_d = S_CAPTURE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    u_axis_d[16*idx_q +: 16] = u_clamped;
                    // Feedback is the unclamped result promoted to the
                    // 32-bit operand scale (sign-extend then << 16).
                    fb_d[32*idx_q +: 32]     = {core_u, 16'b0};
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d      = S_IDLE;
                    sample_req_d = 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags: a clear and a set in the same cycle leaves the
    // flag set so that no event is lost.
    always_comb begin
        overrun_d = clr_err ? 1'b0 : overrun_q;
        timeout_d = clr_err ? 1'b0 : timeout_q;
        if (tick && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
        if (timeout_set) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            idx_q        <= '0;
            sample_req_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            snap_dot_q   <= '0;
            snap_e_q     <= '0;
            snap_dote_q  <= '0;
            fb_q         <= '0;
            u_axis_q     <= '0;
            op_u_t_q     <= '0;
            op_dot_q     <= '0;
            op_e_q       <= '0;
            op_dote_q    <= '0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            idx_q        <= idx_d;
            sample_req_q <= sample_req_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
            snap_dot_q   <= snap_dot_d;
            snap_e_q     <= snap_e_d;
            snap_dote_q  <= snap_dote_d;
            fb_q         <= fb_d;
            u_axis_q     <= u_axis_d;
            op_u_t_q     <= op_u_t_d;
            op_dot_q     <= op_dot_d;
            op_e_q       <= op_e_d;
            op_dote_q    <= op_dote_d;
        end
    end

    assign sample_req      = sample_req_q;
    assign core_u_t        = op_u_t_q;
    assign core_theta_dot  = op_dot_q;
    assign core_theta_e    = op_e_q;
    assign core_theta_dote = op_dote_q;
    assign u_axis          = u_axis_q;
    assign u_valid         = (state_q == S_DONE);
    assign busy            = (state_q != S_IDLE);
    assign overrun_err     = overrun_q;
    assign timeout_err     = timeout_q;

endmodule

// File: tb/tb_smc_axis_scheduler.sv
// Testbench for smc_axis_scheduler. The main instance runs with TICK_DIV=20
// and the default settle/ack/limit parameters; a second instance with
// TICK_DIV=10, SETTLE=4 acks its own request and is deliberately overrun.

module tb_smc_axis_scheduler;

    localparam int N = 4;

    typedef struct {
        logic signed [15:0] coreU;
        logic signed [15:0] expU;
        logic signed [31:0] expFb;
    } satVec_t;

    logic              clk;
    logic              rst;
    logic              en;
    logic              clrErr;
    logic              sampleReq;
    logic              sampleAck;
    logic [32*N-1:0]   thetaDot;
    logic [32*N-1:0]   thetaE;
    logic [32*N-1:0]   thetaDote;
    logic [31:0]       coreUT;
    logic [31:0]       coreThetaDot;
    logic [31:0]       coreThetaE;
    logic [31:0]       coreThetaDote;
    logic [15:0]       coreU;
    logic [16*N-1:0]   uAxis;
    logic              uValid;
    logic              busy;
    logic              overrunErr;
    logic              timeoutErr;

    logic              en2;
    logic              sampleReq2;
    logic [31:0]       coreUT2;
    logic [31:0]       coreThetaDot2;
    logic [31:0]       coreThetaE2;
    logic [31:0]       coreThetaDote2;
    logic [16*N-1:0]   uAxis2;
    logic              uValid2;
    logic              busy2;
    logic              overrunErr2;
    logic              timeoutErr2;

    logic              useModel;
    logic signed [15:0] coreUConst;

    int checks;
    int errors;

    smc_axis_scheduler #(
        .N_AXIS   (N),
        .TICK_DIV (20)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .clr_err         (clrErr),
        .sample_req      (sampleReq),
        .sample_ack      (sampleAck),
        .theta_dot_i     (thetaDot),
        .theta_e_i       (thetaE),
        .theta_dote_i    (thetaDote),
        .core_u_t        (coreUT),
        .core_theta_dot  (coreThetaDot),
        .core_theta_e    (coreThetaE),
        .core_theta_dote (coreThetaDote),
        .core_u          (coreU),
        .u_axis          (uAxis),
        .u_valid         (uValid),
        .busy            (busy),
        .overrun_err     (overrunErr),
        .timeout_err     (timeoutErr)
    );

    smc_axis_scheduler #(
        .N_AXIS   (N),
        .TICK_DIV (10),
        .SETTLE   (4)
    ) dutOverrun (
        .clk             (clk),
        .rst             (rst),
        .en              (en2),
        .clr_err         (1'b0),
        .sample_req      (sampleReq2),
        .sample_ack      (sampleReq2),
        .theta_dot_i     (thetaDot),
        .theta_e_i       (thetaE),
        .theta_dote_i    (thetaDote),
        .core_u_t        (coreUT2),
        .core_theta_dot  (coreThetaDot2),
        .core_theta_e    (coreThetaE2),
        .core_theta_dote (coreThetaDote2),
        .core_u          (16'sd7),
        .u_axis          (uAxis2),
        .u_valid         (uValid2),
        .busy            (busy2),
        .overrun_err     (overrunErr2),
        .timeout_err     (timeoutErr2)
    );

    // Stand-in for the SMC core: either a constant, or a simple sum of two
    // operands so that per-axis routing shows up in the captured lanes.
    always_comb begin
        coreU = coreUConst;
        if (useModel) begin
            coreU = coreThetaDot[15:0] + coreThetaE[15:0];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [31:0] lane(input logic [16*N-1:0] v, input int k);
        return {{16{v[16*k+15]}}, v[16*k +: 16]};
    endfunction

    task automatic checkOutput(input string name, input logic signed [31:0] act,
                               input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int dotStep, input int eStep, input int doteBase);
        for (int k = 0; k < N; k++) begin
            thetaDot[32*k +: 32]  = 32'(dotStep * (k + 1));
            thetaE[32*k +: 32]    = 32'(eStep * (k + 1));
            thetaDote[32*k +: 32] = 32'(doteBase + k);
        end
    endtask

    // Waits for a request, acks it one cycle later, then follows the frame.
    // lat counts cycles from the ack cycle; abortAt drops en (or raises rst)
    // at that lat and returns immediately.
    task automatic runFrame(input int abortAt, input bit useReset, output int lat,
                            output logic signed [31:0] ut0, output logic signed [31:0] td0,
                            output logic signed [31:0] td1, output bit gotValid);
        int waitCnt;
        waitCnt  = 0;
        gotValid = 1'b0;
        lat      = 0;
        ut0      = '0;
        td0      = '0;
        td1      = '0;
        while (sampleReq !== 1'b1 && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("req_seen", sampleReq, 1);
        @(negedge clk);
        sampleAck = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            sampleAck = 1'b0;
            thetaDot  = '1;
            thetaE    = '1;
            thetaDote = '1;
            lat = i;
            if (i == 1) begin
                checkOutput("req_drop_after_ack", sampleReq, 0);
                checkOutput("busy_in_frame", busy, 1);
            end
            if (i == 2) begin
                ut0 = coreUT;
                td0 = coreThetaDot;
            end
            if (i == 6) td1 = coreThetaDot;
            if (i == abortAt) begin
                if (useReset) rst = 1'b1;
                else en = 1'b0;
                break;
            end
            if (uValid) begin
                gotValid = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        satVec_t tbl [9];
        int lat;
        logic signed [31:0] ut0, td0, td1, prevFb;
        bit got;
        bit seenValid, seenReq;
        int cnt, reqCycles;
        int rises, valids, firstReq, firstValid;
        logic prevReq;

        tbl[0] = '{16'sd100,    16'sd100,   32'sd6553600};
        tbl[1] = '{16'sd5000,   16'sd2047,  32'sd327680000};
        tbl[2] = '{16'sh8000,  -16'sd2047,  32'sh80000000};
        tbl[3] = '{16'sd2048,   16'sd2047,  32'sd134217728};
        tbl[4] = '{-16'sd2048, -16'sd2047, -32'sd134217728};
        tbl[5] = '{16'sd2047,   16'sd2047,  32'sd134152192};
        tbl[6] = '{-16'sd2047, -16'sd2047, -32'sd134152192};
        tbl[7] = '{16'sd0,      16'sd0,     32'sd0};
        tbl[8] = '{-16'sd100,  -16'sd100,  -32'sd6553600};

        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        en         = 1'b0;
        en2        = 1'b0;
        clrErr     = 1'b0;
        sampleAck  = 1'b0;
        useModel   = 1'b0;
        coreUConst = '0;
        thetaDot   = '0;
        thetaE     = '0;
        thetaDote  = '0;

        repeat (3) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_sample_req", sampleReq, 0);
        checkOutput("rst_u_valid", uValid, 0);
        checkOutput("rst_u_axis0", lane(uAxis, 0), 0);
        checkOutput("rst_u_axis3", lane(uAxis, 3), 0);
        checkOutput("rst_core_u_t", coreUT, 0);
        checkOutput("rst_overrun", overrunErr, 0);
        checkOutput("rst_timeout", timeoutErr, 0);
        rst = 1'b0;

        // Per-axis routing: each lane must see its own snapshot operands.
        useModel = 1'b1;
        applyStimulus(10, 1, 1000);
        runFrame(0, 1'b0, lat, ut0, td0, td1, got);
        checkOutput("model_valid", got, 1);
        checkOutput("model_latency", lat, 17);
        checkOutput("model_ut_first", ut0, 0);
        checkOutput("model_dot_axis0", td0, 10);
        checkOutput("model_dot_axis1", td1, 20);
        for (int k = 0; k < N; k++) begin
            checkOutput($sformatf("model_lane%0d", k), lane(uAxis, k), 11 * (k + 1));
        end
        checkOutput("hold_theta_e", coreThetaE, 4);
        checkOutput("hold_theta_dote", coreThetaDote, 1003);
        @(negedge clk);
        checkOutput("u_valid_one_cycle", uValid, 0);
        checkOutput("idle_after_done", busy, 0);
        useModel = 1'b0;

        // Saturation table; each frame also checks the previous frame's
        // feedback as the axis-0 u_t operand.
        prevFb = 32'sd720896;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(3, 5, 7);
            coreUConst = tbl[i].coreU;
            runFrame(0, 1'b0, lat, ut0, td0, td1, got);
            checkOutput($sformatf("sat%0d_latency", i), lat, 17);
            checkOutput($sformatf("sat%0d_fb", i), ut0, prevFb);
            for (int k = 0; k < N; k++) begin
                checkOutput($sformatf("sat%0d_lane%0d", i, k), lane(uAxis, k), tbl[i].expU);
            end
            prevFb = tbl[i].expFb;
        end
        checkOutput("no_overrun_normal", overrunErr, 0);
        checkOutput("no_timeout_normal", timeoutErr, 0);

        // en dropped while axis 1 is loading.
        applyStimulus(3, 5, 7);
        coreUConst = 16'sd300;
        runFrame(5, 1'b0, lat, ut0, td0, td1, got);
        @(negedge clk);
        checkOutput("endrop_busy", busy, 0);
        checkOutput("endrop_req", sampleReq, 0);
        checkOutput("endrop_lane0", lane(uAxis, 0), 300);
        checkOutput("endrop_lane1", lane(uAxis, 1), -100);
        checkOutput("endrop_lane3", lane(uAxis, 3), -100);
        seenValid = 1'b0;
        seenReq   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            seenValid |= uValid;
            seenReq   |= sampleReq;
        end
        checkOutput("endrop_no_valid", seenValid, 0);
        checkOutput("endrop_no_req", seenReq, 0);
        en  = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cnt++;
            if (sampleReq) break;
        end
        checkOutput("reenable_first_req", cnt, 20);

        // Ack timeout; clr_err is raised on the edge that sets the flag.
        reqCycles = 0;
        for (int i = 0; i < 200; i++) begin
            if (!sampleReq) break;
            reqCycles++;
            if (reqCycles == 64) begin
                checkOutput("overrun_during_req", overrunErr, 1);
                clrErr = 1'b1;
            end
            @(negedge clk);
        end
        checkOutput("timeout_req_cycles", reqCycles, 64);
        checkOutput("timeout_set_wins", timeoutErr, 1);
        checkOutput("timeout_overrun_cleared", overrunErr, 0);
        checkOutput("timeout_idle", busy, 0);
        checkOutput("timeout_lane0_kept", lane(uAxis, 0), 300);
        checkOutput("timeout_lane2_kept", lane(uAxis, 2), -100);
        @(negedge clk);
        checkOutput("timeout_cleared", timeoutErr, 0);
        clrErr = 1'b0;

        // Reset during the settle wait of axis 2.
        applyStimulus(3, 5, 7);
        coreUConst = 16'sd500;
        runFrame(10, 1'b1, lat, ut0, td0, td1, got);
        @(negedge clk);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_u_valid", uValid, 0);
        checkOutput("midrst_req", sampleReq, 0);
        checkOutput("midrst_lane0", lane(uAxis, 0), 0);
        checkOutput("midrst_lane1", lane(uAxis, 1), 0);
        checkOutput("midrst_core_u_t", coreUT, 0);
        checkOutput("midrst_core_dot", coreThetaDot, 0);
        rst = 1'b0;
        seenValid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seenValid |= uValid;
        end
        checkOutput("midrst_no_valid", seenValid, 0);
        en = 1'b0;

        // Frame longer than the control period on the second instance.
        en2        = 1'b1;
        rises      = 0;
        valids     = 0;
        firstReq   = -1;
        firstValid = -1;
        prevReq    = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (sampleReq2 && !prevReq) begin
                rises++;
                if (firstReq < 0) firstReq = i;
            end
            prevReq = sampleReq2;
            if (uValid2) begin
                valids++;
                if (firstValid < 0) firstValid = i;
            end
            if (valids == 4) break;
        end
        checkOutput("ovr_frames_done", valids, 4);
        checkOutput("ovr_frames_started", rises, 4);
        checkOutput("ovr_frame_latency", firstValid - firstReq, 25);
        checkOutput("ovr_flag", overrunErr2, 1);
        checkOutput("ovr_lane0", lane(uAxis2, 0), 7);
        en2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
